// File: rtl/change_dispenser.sv
// Coin payout engine for the retro vending interface.
// Pays out a refund greedily (25, 10, 5 cents), skipping empty hoppers.
// Each coin gets one eject pulse followed by an idle gap. Any residue that
// cannot be paid is reported as the shortfall.
module change_dispenser #(
    parameter int AMOUNT_W     = 8,
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [AMOUNT_W-1:0] amount,
    input  logic                empty_25,
    input  logic                empty_10,
    input  logic                empty_5,
    output logic                eject_25,
    output logic                eject_10,
    output logic                eject_5,
    output logic                busy,
    output logic                done,
    output logic [AMOUNT_W-1:0] shortfall
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    // A single counter times both the pulse and the gap phases.
    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // Coin table, index 0 = 5c, 1 = 10c, 2 = 25c (higher index wins).
    localparam logic [AMOUNT_W-1:0] COIN_VAL [3] = '{AMOUNT_W'(5), AMOUNT_W'(10), AMOUNT_W'(25)};

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          coin_q, coin_d;        // one-hot, same indexing as COIN_VAL
    logic [AMOUNT_W-1:0] remaining_q, remaining_d;
    logic [AMOUNT_W-1:0] shortfall_q, shortfall_d;

    logic [2:0]          empty_vec;
    logic [2:0]          avail;
    logic [AMOUNT_W-1:0] coin_value;

    assign empty_vec = {empty_25, empty_10, empty_5};

    // A denomination is eligible when its hopper has coins and it still fits.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_avail
            assign avail[gi] = !empty_vec[gi] && (remaining_q >= COIN_VAL[gi]);
        end
    endgenerate

    // Value of the coin currently being ejected.
    always_comb begin
        coin_value = '0;
        for (int i = 0; i < 3; i++) begin
            if (coin_q[i]) coin_value = COIN_VAL[i];
        end
    end

    // State, counter and amount registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            coin_q      <= '0;
            remaining_q <= '0;
            shortfall_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            coin_q      <= coin_d;
            remaining_q <= remaining_d;
            shortfall_q <= shortfall_d;
        end
    end

    // Next-state logic: greedy selection, pulse/gap pacing, completion.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        coin_d      = coin_q;
        remaining_d = remaining_q;
        shortfall_d = shortfall_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = amount;
                    shortfall_d = '0;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                cnt_d = '0;
                if (avail[2]) begin
                    coin_d  = 3'b100;
                    state_d = S_PULSE;
                end else if (avail[1]) begin
                    coin_d  = 3'b010;
                    state_d = S_PULSE;
                end else if (avail[0]) begin
                    coin_d  = 3'b001;
                    state_d = S_PULSE;
                end else begin
                    coin_d      = '0;
                    shortfall_d = remaining_q;
                    state_d     = S_DONE;
                end
            end
            S_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d       = '0;
                    remaining_d = remaining_q - coin_value;
                    state_d     = (GAP_CYCLES == 0) ? S_SELECT : S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SELECT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from registered state only.
    assign eject_25  = (state_q == S_PULSE) && coin_q[2];
    assign eject_10  = (state_q == S_PULSE) && coin_q[1];
    assign eject_5   = (state_q == S_PULSE) && coin_q[0];
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign shortfall = shortfall_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: table of payout vectors with hand-computed
// coin sequences and shortfalls, plus reset-abort and pulse-width cases.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, start2;
    logic [7:0] amount;
    logic       empty_25, empty_10, empty_5;
    logic       eject_25, eject_10, eject_5, busy, done;
    logic [7:0] shortfall;
    logic       eject2_25, eject2_10, eject2_5, busy2, done2;
    logic [7:0] shortfall2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk(clk), .reset(reset), .start(start), .amount(amount),
        .empty_25(empty_25), .empty_10(empty_10), .empty_5(empty_5),
        .eject_25(eject_25), .eject_10(eject_10), .eject_5(eject_5),
        .busy(busy), .done(done), .shortfall(shortfall)
    );

    change_dispenser #(.AMOUNT_W(8), .PULSE_CYCLES(2), .GAP_CYCLES(0)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .amount(amount),
        .empty_25(empty_25), .empty_10(empty_10), .empty_5(empty_5),
        .eject_25(eject2_25), .eject_10(eject2_10), .eject_5(eject2_5),
        .busy(busy2), .done(done2), .shortfall(shortfall2)
    );

    // seq: coin i in bits [2i+1:2i]; 3 = 25c, 2 = 10c, 1 = 5c
    typedef struct {
        logic [7:0]  amount;
        logic [2:0]  empty;     // {25,10,5}
        int          ncoins;
        logic [15:0] seq;
        logic [7:0]  short_exp;
        bit          restart;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2:0] code2oh(input logic [1:0] c);
        case (c)
            2'd3:    return 3'b100;
            2'd2:    return 3'b010;
            2'd1:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Start one payout and follow it cycle by cycle against the expected trace.
    task automatic run_vec(input string tag, input vec_t v, input int p, input int g, input bit sel2);
        int per, done_cyc, trace_err, done_err, busy_err, short_got, hold_got;
        logic [2:0] e, exp_e;
        logic b, d;
        logic [7:0] sf;
        logic [1:0] code;
        per       = 1 + p + g;
        done_cyc  = 2 + v.ncoins * per;
        trace_err = 0; done_err = 0; busy_err = 0; short_got = -1; hold_got = -1;
        @(negedge clk);
        amount   = v.amount;
        {empty_25, empty_10, empty_5} = v.empty;
        if (sel2) start2 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; start2 = 1'b0;
        for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
            @(negedge clk);
            if (sel2) begin
                e = {eject2_25, eject2_10, eject2_5}; b = busy2; d = done2; sf = shortfall2;
            end else begin
                e = {eject_25, eject_10, eject_5}; b = busy; d = done; sf = shortfall;
            end
            exp_e = 3'b000;
            for (int i = 0; i < v.ncoins; i++) begin
                code = v.seq[2*i +: 2];
                if (cyc >= 2 + i * per && cyc < 2 + i * per + p) exp_e = code2oh(code);
            end
            if (e !== exp_e) trace_err++;
            if (d !== (cyc == done_cyc)) done_err++;
            if (b !== (cyc <= done_cyc)) busy_err++;
            if (cyc == done_cyc) short_got = int'(sf);
            if (cyc == done_cyc + 1) hold_got = int'(sf);
            if (v.restart && cyc == 4) begin
                amount = 8'd99;
                if (sel2) start2 = 1'b1; else start = 1'b1;
            end
            if (v.restart && cyc == 5) begin
                amount = v.amount;
                start = 1'b0; start2 = 1'b0;
            end
        end
        check({tag, " eject_trace_bad_cycles"}, trace_err, 0);
        check({tag, " done_bad_cycles"}, done_err, 0);
        check({tag, " busy_bad_cycles"}, busy_err, 0);
        check({tag, " shortfall"}, short_got, int'(v.short_exp));
        check({tag, " shortfall_hold"}, hold_got, int'(v.short_exp));
        $display("%s: amount=%0d empty=%b coins=%0d shortfall=%0d done_cycle=N+%0d",
                 tag, v.amount, v.empty, v.ncoins, short_got, done_cyc);
    endtask

    initial begin
        int done_seen;
        vec_t v;
        vecs[0] = '{8'd40, 3'b000, 3, 16'h001B, 8'd0, 1'b0};  // 25,10,5
        vecs[1] = '{8'd30, 3'b100, 3, 16'h002A, 8'd0, 1'b0};  // 10,10,10
        vecs[2] = '{8'd30, 3'b011, 1, 16'h0003, 8'd5, 1'b0};  // 25, short 5
        vecs[3] = '{8'd7,  3'b000, 1, 16'h0001, 8'd2, 1'b0};  // 5, short 2
        vecs[4] = '{8'd0,  3'b000, 0, 16'h0000, 8'd0, 1'b0};  // nothing
        vecs[5] = '{8'd65, 3'b000, 4, 16'h006F, 8'd0, 1'b0};  // 25,25,10,5
        vecs[6] = '{8'd3,  3'b000, 0, 16'h0000, 8'd3, 1'b0};  // short 3
        vecs[7] = '{8'd20, 3'b010, 4, 16'h0055, 8'd0, 1'b0};  // 5,5,5,5
        vecs[8] = '{8'd40, 3'b000, 3, 16'h001B, 8'd0, 1'b1};  // start while busy
        vecs[9] = '{8'd12, 3'b001, 1, 16'h0002, 8'd2, 1'b0};  // 10, short 2

        reset = 1'b1; start = 1'b0; start2 = 1'b0; amount = 8'd0;
        empty_25 = 1'b0; empty_10 = 1'b0; empty_5 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'({eject_25, eject_10, eject_5, busy, done}), 0);
        check("reset_shortfall", int'(shortfall), 0);
        check("reset_outputs_dut2", int'({eject2_25, eject2_10, eject2_5, busy2, done2}), 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i], 1, 4, 1'b0);

        // Reset during the second coin of a 50c payout.
        @(negedge clk);
        amount = 8'd50; {empty_25, empty_10, empty_5} = 3'b000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) @(negedge clk);
        check("abort_second_pulse_high", int'(eject_25), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_outputs_cleared", int'({eject_25, eject_10, eject_5, busy, done}), 0);
        check("abort_shortfall_cleared", int'(shortfall), 0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (done || busy || eject_25 || eject_10 || eject_5) done_seen++;
        end
        check("abort_no_activity_after", done_seen, 0);
        v = '{8'd25, 3'b000, 1, 16'h0003, 8'd0, 1'b0};
        run_vec("after_abort", v, 1, 4, 1'b0);

        // Two-cycle pulses, no gap.
        v = '{8'd40, 3'b000, 3, 16'h001B, 8'd0, 1'b0};
        run_vec("p2g0_40", v, 2, 0, 1'b1);
        v = '{8'd30, 3'b100, 3, 16'h002A, 8'd0, 1'b0};
        run_vec("p2g0_30", v, 2, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Payout side of the retro vending coin interface. Accepts a refund amount in cents and drives the coin hopper ejectors, one paced pulse per coin. Selection is greedy: largest coin first, skipping denominations whose hopper reports empty. Sits beside the vending controller and is started when change or a refund is owed; coin pulse widths match the accept-side convention of one clock per coin.

## Interface
- AMOUNT_W, 8: width of amount/shortfall in cents; must be ≥ 5
- PULSE_CYCLES, 1: cycles each eject pulse is held high; ≥ 1
- GAP_CYCLES, 4: idle cycles after each pulse before next selection; ≥ 0

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  load request; sampled only in IDLE
- amount  in  AMOUNT_W  cents to pay out, sampled with start
- empty_25 / empty_10 / empty_5  in  1 each  hopper empty flags
- eject_25 / eject_10 / eject_5  out  1 each  coin eject pulses
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- shortfall  out  AMOUNT_W  cents not paid, valid from done until next start

## Operation
- States: IDLE, SELECT, PULSE, GAP, DONE. Eject, busy, and done outputs are decoded from the registered state/coin registers (Moore). No combinational path from inputs to outputs.
- IDLE, start=1: latch remaining=amount, clear shortfall to 0, go to SELECT.
- IDLE, start=1, amount=0: go to SELECT. SELECT finds nothing and goes to DONE with shortfall 0.
- SELECT: choose c = first of 25, 10, 5 with remaining ≥ c and empty_c=0.
  - Coin found: latch coin, go to PULSE.
  - No coin found: go to DONE.
- PULSE: hold eject_c high for PULSE_CYCLES cycles. Only one eject is ever high.
  - On the last pulse cycle: remaining -= c. Underflow is impossible by the selection rule.
  - Then go to GAP, or to SELECT if GAP_CYCLES=0.
- GAP: all ejects low for GAP_CYCLES cycles, then go to SELECT.
- DONE: done=1 for exactly one cycle and shortfall=remaining, then go to IDLE.
  - shortfall holds until the next accepted start.
- Hopper empty flags are evaluated only in SELECT. A flag changing during PULSE/GAP does not abort the current coin.
- Amounts not a multiple of 5: residual 1–4 cents is reported in shortfall.
- start while busy is ignored. amount changes while busy are ignored.

## Timing
- Reset values: all ejects 0, busy 0, done 0, shortfall 0, state IDLE, remaining 0.
- Reset mid-operation: outputs return to reset values on the next edge. Any active pulse is truncated and no done is generated.
- start sampled at edge N: SELECT in cycle N+1, first eject high in cycles N+2 … N+1+PULSE_CYCLES.
- Per-coin period: 1 + PULSE_CYCLES + GAP_CYCLES cycles (6 with defaults).
- Completion for k coins: final SELECT in cycle N+1+k·(1+PULSE_CYCLES+GAP_CYCLES). DONE (done=1) follows in the next cycle. busy drops the cycle after DONE.
- Back-to-back: start may be accepted in the first IDLE cycle after DONE.

## Test plan
- Amount 40, all hoppers full, defaults, start at edge N:
  - eject_25 in cycle N+2, eject_10 in N+8, eject_5 in N+14.
  - done in N+20, shortfall 0, busy high N+1…N+20.
- Amount 30, empty_25=1:
  - ejects are 10, 10, 10; done with shortfall 0.
- Amount 30, empty_10=1, empty_5=1:
  - one eject_25, then done with shortfall 5.
- Amount 7:
  - one eject_5, done with shortfall 2.
- Amount 0:
  - no ejects, done in cycle N+2, shortfall 0.
- Reset asserted during the second pulse of amount 50:
  - all outputs 0 on the next edge, no done.
  - A new start with amount 25 then yields exactly one eject_25 and done.
- start pulsed again while busy:
  - ignored; the coin sequence is unchanged.
- PULSE_CYCLES=2, GAP_CYCLES=0:
  - each eject high exactly 2 cycles, per-coin period 3.
